// File: rtl/lcd_nibble_rx.sv
// rtl/lcd_nibble_rx.sv - 4-bit character-LCD bus receiver and HD44780-style decoder
// Tracks the 3,3,3,2 init handshake, pairs nibbles into bytes, decodes commands/data to a DDRAM stream.
module lcd_nibble_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_W      = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sf_e,
   input  logic              e,
   input  logic              rs,
   input  logic              rw,
   input  logic              d,
   input  logic              c,
   input  logic              b,
   input  logic              a,
   output logic              mode4,
   output logic              byte_valid,
   output logic [7:0]        byte_out,
   output logic              byte_is_data,
   output logic              char_valid,
   output logic [7:0]        char_code,
   output logic [ADDR_W-1:0] char_addr,
   output logic [ADDR_W-1:0] ddram_addr,
   output logic              disp_on,
   output logic              proto_err
);

   typedef enum logic [1:0] {INIT_WAIT, INIT_3, HI, LO} state_t;

   logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
   logic              e_d1_q, e_d1_d;
   state_t            state_q, state_d;
   logic [3:0]        hi_nib_q, hi_nib_d;
   logic              hi_rs_q, hi_rs_d;
   logic              mode4_q, mode4_d;
   logic              byte_valid_q, byte_valid_d;
   logic [7:0]        byte_out_q, byte_out_d;
   logic              byte_is_data_q, byte_is_data_d;
   logic              char_valid_q, char_valid_d;
   logic [7:0]        char_code_q, char_code_d;
   logic [ADDR_W-1:0] char_addr_q, char_addr_d;
   logic [ADDR_W-1:0] ddram_addr_q, ddram_addr_d;
   logic              id_q, id_d;
   logic              disp_on_q, disp_on_d;
   logic              proto_err_q, proto_err_d;

   logic [7:0] bus_s;
   logic       strobe;
   logic [3:0] nib;
   logic       nib_rs;
   logic       do_asm;
   logic [7:0] asm_byte;

   // Synchronized bus bit order: {sf_e, e, rs, rw, d, c, b, a}
   assign bus_s  = sync_q[SYNC_STAGES-1];
   assign nib    = bus_s[3:0];
   assign nib_rs = bus_s[5];
   assign strobe = e_d1_q & ~bus_s[6] & bus_s[7] & ~bus_s[4];

   always_comb begin
      sync_d[0] = {sf_e, e, rs, rw, d, c, b, a};
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      e_d1_d         = bus_s[6];
      state_d        = state_q;
      hi_nib_d       = hi_nib_q;
      hi_rs_d        = hi_rs_q;
      mode4_d        = mode4_q;
      byte_valid_d   = 1'b0;
      byte_out_d     = byte_out_q;
      byte_is_data_d = byte_is_data_q;
      char_valid_d   = 1'b0;
      char_code_d    = char_code_q;
      char_addr_d    = char_addr_q;
      ddram_addr_d   = ddram_addr_q;
      id_d           = id_q;
      disp_on_d      = disp_on_q;
      proto_err_d    = proto_err_q;
      do_asm         = 1'b0;
      asm_byte       = {hi_nib_q, nib};

      if (strobe) begin
         case (state_q)
            INIT_WAIT: if (!nib_rs && nib == 4'h3) state_d = INIT_3;
            INIT_3: begin
               if (nib == 4'h2) begin
                  state_d = HI;
                  mode4_d = 1'b1;
               end else if (nib != 4'h3) begin
                  state_d = INIT_WAIT;
               end
            end
            HI: begin
               hi_nib_d = nib;
               hi_rs_d  = nib_rs;
               state_d  = LO;
            end
            LO: begin
               if (nib_rs == hi_rs_q) begin
                  do_asm  = 1'b1;
                  state_d = HI;
               end else begin
                  // A stray rs change means we lost alignment; restart the pair from this nibble
                  proto_err_d = 1'b1;
                  hi_nib_d    = nib;
                  hi_rs_d     = nib_rs;
               end
            end
            default: state_d = INIT_WAIT;
         endcase
      end

      if (do_asm) begin
         byte_valid_d   = 1'b1;
         byte_out_d     = asm_byte;
         byte_is_data_d = hi_rs_q;
         if (hi_rs_q) begin
            char_valid_d = 1'b1;
            char_code_d  = asm_byte;
            char_addr_d  = ddram_addr_q;
            ddram_addr_d = id_q ? ddram_addr_q + ADDR_W'(1) : ddram_addr_q - ADDR_W'(1);
         end else if (asm_byte == 8'h01) begin
            ddram_addr_d = '0;
            id_d         = 1'b1;
         end else if (asm_byte[7:1] == 7'h01) begin
            ddram_addr_d = '0;
         end else if (asm_byte[7:2] == 6'h01) begin
            id_d = asm_byte[1];
         end else if (asm_byte[7:3] == 5'h01) begin
            disp_on_d = asm_byte[2];
         end else if (asm_byte[7]) begin
            ddram_addr_d = ADDR_W'(asm_byte[6:0]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q         <= '0;
         e_d1_q         <= 1'b0;
         state_q        <= INIT_WAIT;
         hi_nib_q       <= 4'h0;
         hi_rs_q        <= 1'b0;
         mode4_q        <= 1'b0;
         byte_valid_q   <= 1'b0;
         byte_out_q     <= 8'h00;
         byte_is_data_q <= 1'b0;
         char_valid_q   <= 1'b0;
         char_code_q    <= 8'h00;
         char_addr_q    <= '0;
         ddram_addr_q   <= '0;
         id_q           <= 1'b1;
         disp_on_q      <= 1'b0;
         proto_err_q    <= 1'b0;
      end else begin
         sync_q         <= sync_d;
         e_d1_q         <= e_d1_d;
         state_q        <= state_d;
         hi_nib_q       <= hi_nib_d;
         hi_rs_q        <= hi_rs_d;
         mode4_q        <= mode4_d;
         byte_valid_q   <= byte_valid_d;
         byte_out_q     <= byte_out_d;
         byte_is_data_q <= byte_is_data_d;
         char_valid_q   <= char_valid_d;
         char_code_q    <= char_code_d;
         char_addr_q    <= char_addr_d;
         ddram_addr_q   <= ddram_addr_d;
         id_q           <= id_d;
         disp_on_q      <= disp_on_d;
         proto_err_q    <= proto_err_d;
      end
   end

   assign mode4        = mode4_q;
   assign byte_valid   = byte_valid_q;
   assign byte_out     = byte_out_q;
   assign byte_is_data = byte_is_data_q;
   assign char_valid   = char_valid_q;
   assign char_code    = char_code_q;
   assign char_addr    = char_addr_q;
   assign ddram_addr   = ddram_addr_q;
   assign disp_on      = disp_on_q;
   assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_lcd_nibble_rx.sv
// tb/tb_lcd_nibble_rx.sv - directed bench for lcd_nibble_rx with byte/char scoreboards
module tb_lcd_nibble_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sf_e = 1'b1, e = 1'b0, rs = 1'b0, rw = 1'b0;
   logic       d = 1'b0, c = 1'b0, b = 1'b0, a = 1'b0;
   logic       mode4, byte_valid, byte_is_data, char_valid, disp_on, proto_err;
   logic [7:0] byte_out, char_code;
   logic [6:0] char_addr, ddram_addr;

   int n_checks = 0;
   int n_errors = 0;
   logic [8:0]  byte_q[$];
   logic [14:0] char_q[$];

   lcd_nibble_rx #(.SYNC_STAGES(2), .ADDR_W(7)) dut (
      .clk(clk), .rst_n(rst_n), .sf_e(sf_e), .e(e), .rs(rs), .rw(rw),
      .d(d), .c(c), .b(b), .a(a),
      .mode4(mode4), .byte_valid(byte_valid), .byte_out(byte_out),
      .byte_is_data(byte_is_data), .char_valid(char_valid), .char_code(char_code),
      .char_addr(char_addr), .ddram_addr(ddram_addr), .disp_on(disp_on),
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every pulse must match the oldest expectation
   always @(negedge clk) begin
      if (byte_valid) begin
         chk("byte_expected", 16'(byte_q.size() != 0), 16'd1);
         if (byte_q.size() != 0) chk("byte", {7'h0, byte_is_data, byte_out}, {7'h0, byte_q.pop_front()});
      end
      if (char_valid) begin
         chk("char_expected", 16'(char_q.size() != 0), 16'd1);
         if (char_q.size() != 0) chk("char", {1'b0, char_code, char_addr}, {1'b0, char_q.pop_front()});
      end
   end

   task automatic strobe(input logic q_sf, input logic q_rw, input logic r, input logic [3:0] v);
      sf_e = q_sf; rw = q_rw; rs = r; {d, c, b, a} = v;
      e = 1'b1;
      repeat (3) @(posedge clk);
      #1 e = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic nib(input logic r, input logic [3:0] v);
      strobe(1'b1, 1'b0, r, v);
   endtask

   task automatic send_byte(input logic r, input logic [7:0] v);
      byte_q.push_back({r, v});
      nib(r, v[7:4]);
      nib(r, v[3:0]);
   endtask

   task automatic init_seq();
      nib(1'b0, 4'h3); nib(1'b0, 4'h3); nib(1'b0, 4'h3); nib(1'b0, 4'h2);
   endtask

   task automatic drained(input string tag);
      chk(tag, 16'(byte_q.size() + char_q.size()), 16'd0);
   endtask

   task automatic check_all_zero(input string tag);
      chk(tag, {mode4, byte_valid, byte_is_data, char_valid, disp_on, proto_err, 10'h0}, 16'h0);
      chk(tag, {byte_out, char_code}, 16'h0);
      chk(tag, {2'b0, char_addr, ddram_addr}, 16'h0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset_state");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Init and display of "5"
      nib(1'b0, 4'h3); nib(1'b0, 4'h3); nib(1'b0, 4'h3);
      chk("mode4_before_2", 16'(mode4), 16'd0);
      nib(1'b0, 4'h2);
      chk("mode4_after_init", 16'(mode4), 16'd1);
      send_byte(1'b0, 8'h28);
      send_byte(1'b0, 8'h06);
      send_byte(1'b0, 8'h0C);
      send_byte(1'b0, 8'h01);
      char_q.push_back({8'h35, 7'h00});
      send_byte(1'b1, 8'h35);
      chk("addr_after_5", 16'(ddram_addr), 16'h01);
      chk("disp_on", 16'(disp_on), 16'd1);
      strobe(1'b1, 1'b1, 1'b0, 4'h1);
      strobe(1'b1, 1'b1, 1'b0, 4'h0);
      drained("drain_first_pass");

      // Replayed printer loop stays byte-aligned
      send_byte(1'b0, 8'h33);
      send_byte(1'b0, 8'h32);
      send_byte(1'b0, 8'h28);
      send_byte(1'b0, 8'h06);
      send_byte(1'b0, 8'h0C);
      send_byte(1'b0, 8'h01);
      char_q.push_back({8'h35, 7'h00});
      send_byte(1'b1, 8'h35);
      chk("mode4_kept", 16'(mode4), 16'd1);
      chk("addr_second_pass", 16'(ddram_addr), 16'h01);
      drained("drain_second_pass");

      // Address wrap up and down
      send_byte(1'b0, 8'hFF);
      chk("set_addr_7f", 16'(ddram_addr), 16'h7F);
      char_q.push_back({8'h41, 7'h7F});
      send_byte(1'b1, 8'h41);
      chk("wrap_up", 16'(ddram_addr), 16'h00);
      send_byte(1'b0, 8'h04);
      char_q.push_back({8'h42, 7'h00});
      send_byte(1'b1, 8'h42);
      chk("wrap_down", 16'(ddram_addr), 16'h7F);
      chk("byte_out_hold", {7'h0, byte_is_data, byte_out}, 16'h0142);
      drained("drain_wrap");

      // rs mismatch inside a pair
      chk("proto_err_clear", 16'(proto_err), 16'd0);
      nib(1'b1, 4'h3);
      nib(1'b0, 4'h4);
      chk("proto_err_set", 16'(proto_err), 16'd1);
      byte_q.push_back({1'b0, 8'h41});
      nib(1'b0, 4'h1);
      chk("cgram_ignored", 16'(ddram_addr), 16'h7F);
      chk("proto_err_sticky", 16'(proto_err), 16'd1);
      drained("drain_mismatch");

      // Qualification: sf_e=0 and rw=1 strobes are ignored
      @(posedge clk);
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) strobe(1'b0, 1'b0, 1'b0, 4'h3);
      for (int i = 0; i < 10; i++) strobe(1'b1, 1'b1, 1'b0, 4'h3);
      nib(1'b0, 4'h2);
      chk("qual_no_mode4", 16'(mode4), 16'd0);
      init_seq();
      chk("qual_mode4", 16'(mode4), 16'd1);
      send_byte(1'b0, 8'h0C);
      char_q.push_back({8'h35, 7'h00});
      send_byte(1'b1, 8'h35);
      drained("drain_qual");

      // Async reset between the halves of a data byte
      nib(1'b1, 4'h4);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      nib(1'b1, 4'h1);
      nib(1'b0, 4'h2);
      chk("restart_no_mode4", 16'(mode4), 16'd0);
      init_seq();
      chk("restart_mode4", 16'(mode4), 16'd1);
      send_byte(1'b0, 8'h06);
      chk("restart_addr", 16'(ddram_addr), 16'h00);
      drained("drain_restart");

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
